// File: rtl/inc_reg_ctrl_if.sv
// Purpose : bundles the sequencer request side and the register control side of inc_reg_ctrl.
// Latency : n/a (wires only).
// Backpres: none; start is a level sampled only when the controller is idle.
// Ports   : start/abort/start_val/end_val from the sequencer, reg_q feedback from the register,
//           reg_clear/reg_load/reg_inr/reg_data to the register, busy/done/steps/err status.
interface inc_reg_ctrl_if;
    logic       start;
    logic       abort;
    logic [3:0] start_val;
    logic [3:0] end_val;
    logic [3:0] reg_q;
    logic       reg_clear;
    logic       reg_load;
    logic       reg_inr;
    logic [3:0] reg_data;
    logic       busy;
    logic       done;
    logic [3:0] steps;
    logic       err;

    // Controller side.
    modport slave (
        input  start, abort, start_val, end_val, reg_q,
        output reg_clear, reg_load, reg_inr, reg_data, busy, done, steps, err
    );

    // Sequencer / register side.
    modport master (
        output start, abort, start_val, end_val, reg_q,
        input  reg_clear, reg_load, reg_inr, reg_data, busy, done, steps, err
    );
endinterface

// File: rtl/inc_reg_ctrl.sv
// Purpose : drives a 4-bit clear/load/inc register from start_val to end_val (mod 16) and checks its q.
// Latency : done pulses in cycle 3+N after the start edge, N = (end_val - start_val) mod 16.
// Backpres: start ignored while busy; abort returns to IDLE from CLR/LOAD/COUNT without done.
// Ports   : clk, clear (sync active-high reset), bus (inc_reg_ctrl_if.slave) carrying the
//           sequencer request, register controls/feedback and busy/done/steps/err status.
module inc_reg_ctrl (
    input  logic         clk,
    input  logic         clear,
    inc_reg_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLR   = 3'd1,
        S_LOAD  = 3'd2,
        S_COUNT = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] s_reg_q, s_reg_d;
    logic [3:0] e_reg_q, e_reg_d;
    logic [3:0] shadow_q, shadow_d;
    logic [3:0] steps_q, steps_d;
    logic       err_q, err_d;

    logic       reg_clear_c, reg_load_c, reg_inr_c, busy_c, done_c;
    logic [3:0] reg_data_c;
    logic [3:0] shadow_inc;

    // Value the register should hold after the increment issued this cycle.
    assign shadow_inc = shadow_q + 4'd1;

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q  <= S_IDLE;
            s_reg_q  <= 4'd0;
            e_reg_q  <= 4'd0;
            shadow_q <= 4'd0;
            steps_q  <= 4'd0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            s_reg_q  <= s_reg_d;
            e_reg_q  <= e_reg_d;
            shadow_q <= shadow_d;
            steps_q  <= steps_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        s_reg_d     = s_reg_q;
        e_reg_d     = e_reg_q;
        shadow_d    = shadow_q;
        steps_d     = steps_q;
        err_d       = err_q;
        reg_clear_c = 1'b0;
        reg_load_c  = 1'b0;
        reg_inr_c   = 1'b0;
        reg_data_c  = 4'd0;
        busy_c      = 1'b0;
        done_c      = 1'b0;

        case (state_q)
            S_IDLE: begin
                // abort is meaningless here, so a coincident start still wins.
                if (bus.start) begin
                    s_reg_d = bus.start_val;
                    e_reg_d = bus.end_val;
                    steps_d = 4'd0;
                    err_d   = 1'b0;
                    state_d = S_CLR;
                end
            end

            S_CLR: begin
                reg_clear_c = 1'b1;
                busy_c      = 1'b1;
                state_d     = bus.abort ? S_IDLE : S_LOAD;
            end

            S_LOAD: begin
                reg_load_c = 1'b1;
                reg_data_c = s_reg_q;
                busy_c     = 1'b1;
                if (bus.abort) begin
                    state_d = S_IDLE;
                end else begin
                    shadow_d = s_reg_q;
                    state_d  = (s_reg_q == e_reg_q) ? S_DONE : S_COUNT;
                end
            end

            S_COUNT: begin
                reg_inr_c = 1'b1;
                busy_c    = 1'b1;
                // An aborted cycle leaves steps/err/shadow exactly as they were.
                if (bus.abort) begin
                    state_d = S_IDLE;
                end else begin
                    // reg_q still shows the value before this cycle's increment lands.
                    if (bus.reg_q != shadow_q) begin
                        err_d = 1'b1;
                    end
                    shadow_d = shadow_inc;
                    steps_d  = steps_q + 4'd1;
                    if (shadow_inc == e_reg_q) begin
                        state_d = S_DONE;
                    end
                end
            end

            S_DONE: begin
                done_c = 1'b1;
                busy_c = 1'b1;
                // Final value check; shadow equals e_reg here.
                if (bus.reg_q != shadow_q) begin
                    err_d = 1'b1;
                end
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.reg_clear = reg_clear_c;
    assign bus.reg_load  = reg_load_c;
    assign bus.reg_inr   = reg_inr_c;
    assign bus.reg_data  = reg_data_c;
    assign bus.busy      = busy_c;
    assign bus.done      = done_c;
    assign bus.steps     = steps_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_inc_reg_ctrl.sv
// Purpose : scoreboard bench for inc_reg_ctrl with a behavioural 4-bit register on the feedback path.
// Latency : expected events carry the absolute cycle they must appear in.
// Backpres: n/a.
module tb_inc_reg_ctrl;

    logic clk;
    logic clear;
    bit   fault_mode;   // when set, the register model ignores reg_inr
    int   cyc;
    int   n_cmp;
    int   n_bad;

    inc_reg_ctrl_if bus ();

    inc_reg_ctrl dut (
        .clk   (clk),
        .clear (clear),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural register: clear > load > inr.
    always @(posedge clk) begin
        if (bus.reg_clear)                   bus.reg_q <= 4'd0;
        else if (bus.reg_load)               bus.reg_q <= bus.reg_data;
        else if (bus.reg_inr && !fault_mode) bus.reg_q <= bus.reg_q + 4'd1;
    end

    // kind: 0 clear, 1 load, 2 inr, 3 done
    typedef struct {
        int         cyc;
        int         kind;
        logic [3:0] data;
        logic [3:0] q;
        bit         chk_q;
        logic [3:0] steps;
        logic       err;
    } ev_t;

    typedef struct {
        int         cyc;
        int         id;
        logic       busy;
        logic       done;
        logic [2:0] ctrl;
        logic [3:0] data;
        logic [3:0] steps;
        logic       err;
    } st_t;

    ev_t ev_q[$];
    st_t st_q[$];

    // Monitor: pops expectations whenever the DUT shows a register command or done.
    always @(negedge clk) begin : mon
        ev_t        ex;
        st_t        se;
        int         nact;
        int         kind;
        logic [2:0] ctrl;
        while (ev_q.size() > 0 && ev_q[0].cyc < cyc) begin
            ex = ev_q.pop_front();
            n_cmp++; n_bad++;
            $display("FAIL missing_event kind=%0d due cyc %0d not seen (now cyc %0d)", ex.kind, ex.cyc, cyc);
        end
        while (st_q.size() > 0 && st_q[0].cyc < cyc) begin
            se = st_q.pop_front();
            n_cmp++; n_bad++;
            $display("FAIL missed_status id=%0d due cyc %0d", se.id, se.cyc);
        end
        ctrl = {bus.reg_clear, bus.reg_load, bus.reg_inr};
        nact = int'(bus.reg_clear) + int'(bus.reg_load) + int'(bus.reg_inr) + int'(bus.done);
        if (nact > 1) begin
            n_cmp++; n_bad++;
            $display("FAIL onehot cyc=%0d got ctrl=%b done=%b, expected at most one high", cyc, ctrl, bus.done);
        end else if (nact == 1) begin
            kind = bus.reg_clear ? 0 : bus.reg_load ? 1 : bus.reg_inr ? 2 : 3;
            n_cmp++;
            if (ev_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_event cyc=%0d got kind=%0d, expected none", cyc, kind);
            end else begin
                ex = ev_q.pop_front();
                if (kind != ex.kind || cyc != ex.cyc || bus.reg_data !== ex.data ||
                    bus.steps !== ex.steps || bus.err !== ex.err || bus.busy !== 1'b1 ||
                    (ex.chk_q && bus.reg_q !== ex.q)) begin
                    n_bad++;
                    $display("FAIL event got kind=%0d cyc=%0d data=%h q=%h steps=%0d err=%b busy=%b, expected kind=%0d cyc=%0d data=%h q=%h(chk %0d) steps=%0d err=%b busy=1",
                             kind, cyc, bus.reg_data, bus.reg_q, bus.steps, bus.err, bus.busy,
                             ex.kind, ex.cyc, ex.data, ex.q, ex.chk_q, ex.steps, ex.err);
                end
            end
        end
        while (st_q.size() > 0 && st_q[0].cyc == cyc) begin
            se = st_q.pop_front();
            n_cmp++;
            if (bus.busy !== se.busy || bus.done !== se.done || ctrl !== se.ctrl ||
                bus.reg_data !== se.data || bus.steps !== se.steps || bus.err !== se.err) begin
                n_bad++;
                $display("FAIL status id=%0d cyc=%0d got busy=%b done=%b ctrl=%b data=%h steps=%0d err=%b, expected busy=%b done=%b ctrl=%b data=%h steps=%0d err=%b",
                         se.id, cyc, bus.busy, bus.done, ctrl, bus.reg_data, bus.steps, bus.err,
                         se.busy, se.done, se.ctrl, se.data, se.steps, se.err);
            end
        end
    end

    task automatic push_ev(input int c, input int kind, input logic [3:0] data, input logic [3:0] q,
                           input bit chk_q, input logic [3:0] steps, input logic err);
        ev_t e;
        e.cyc = c; e.kind = kind; e.data = data; e.q = q; e.chk_q = chk_q; e.steps = steps; e.err = err;
        ev_q.push_back(e);
    endtask

    // Idle status: no commands, no done, reg_data 0.
    task automatic push_idle(input int c, input int id, input logic [3:0] steps, input logic err);
        st_t s;
        s.cyc = c; s.id = id; s.busy = 1'b0; s.done = 1'b0; s.ctrl = 3'b000;
        s.data = 4'd0; s.steps = steps; s.err = err;
        st_q.push_back(s);
    endtask

    task automatic wait_cyc(input int target);
        for (int i = 0; i < 200 && cyc < target; i++) @(negedge clk);
    endtask

    // One run. stop_k >= 0 interrupts in COUNT cycle k (abort, or clear when use_clear).
    // poke re-pulses start with other operands during CLR.
    task automatic do_run(input logic [3:0] s, input logic [3:0] e, input bit fault,
                          input int stop_k, input bit use_clear, input bit poke, input int id);
        int         c0;
        int         n;
        int         last;
        logic [3:0] d;
        logic [3:0] qk;
        @(negedge clk);
        fault_mode    = fault;
        bus.start_val = s;
        bus.end_val   = e;
        bus.start     = 1'b1;
        @(posedge clk); #1;
        c0 = cyc;
        bus.start     = 1'b0;
        bus.start_val = ~s;   // operands must have been captured at the start edge
        bus.end_val   = ~e;
        d = e - s;
        n = int'(d);
        push_ev(c0,     0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0);
        push_ev(c0 + 1, 1, s,    4'd0, 1'b1, 4'd0, 1'b0);
        for (int k = 0; k < n; k++) begin
            if (stop_k < 0 || k <= stop_k) begin
                qk = fault ? s : s + 4'(k);
                push_ev(c0 + 2 + k, 2, 4'd0, qk, 1'b1, 4'(k), fault && (k >= 2));
            end
        end
        if (stop_k < 0) begin
            push_ev(c0 + 2 + n, 3, 4'd0, fault ? s : e, 1'b1, 4'(n), fault && (n >= 2));
            push_idle(c0 + 3 + n, id, 4'(n), fault && (n >= 2));
            last = c0 + 2 + n;
        end else begin
            push_idle(c0 + 3 + stop_k, id, use_clear ? 4'd0 : 4'(stop_k), 1'b0);
            last = c0 + 3 + stop_k;
        end
        if (poke) begin
            @(negedge clk);
            bus.start     = 1'b1;
            bus.start_val = 4'd9;
            bus.end_val   = 4'd9;
            @(posedge clk); #1;
            bus.start     = 1'b0;
        end
        if (stop_k >= 0) begin
            wait_cyc(c0 + 2 + stop_k);
            if (use_clear) clear = 1'b1;
            else           bus.abort = 1'b1;
            @(posedge clk); #1;
            clear     = 1'b0;
            bus.abort = 1'b0;
        end
        wait_cyc(last);
    endtask

    initial begin
        n_cmp         = 0;
        n_bad         = 0;
        fault_mode    = 1'b0;
        clear         = 1'b1;
        bus.start     = 1'b1;
        bus.abort     = 1'b0;
        bus.start_val = 4'd5;
        bus.end_val   = 4'd9;
        // Reset held 2 cycles with start high: everything stays idle.
        push_idle(1, 100, 4'd0, 1'b0);
        push_idle(2, 101, 4'd0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        clear     = 1'b0;
        bus.start = 1'b0;

        do_run(4'd5,  4'd9,  1'b0, -1, 1'b0, 1'b0, 1);  // basic, back-to-back with next
        do_run(4'd14, 4'd2,  1'b0, -1, 1'b0, 1'b0, 2);  // wrap 15 -> 0
        do_run(4'd7,  4'd7,  1'b0, -1, 1'b0, 1'b0, 3);  // no increments
        do_run(4'd3,  4'd2,  1'b0, -1, 1'b0, 1'b0, 4);  // full span, 15 steps
        do_run(4'd5,  4'd8,  1'b1, -1, 1'b0, 1'b0, 5);  // register ignores inr -> err sticky
        do_run(4'd2,  4'd4,  1'b0, -1, 1'b0, 1'b1, 6);  // err cleared; start during CLR ignored
        do_run(4'd0,  4'd15, 1'b0,  6, 1'b0, 1'b0, 7);  // abort after 6 increments
        do_run(4'd0,  4'd5,  1'b0,  2, 1'b1, 1'b0, 8);  // reset mid-COUNT
        do_run(4'd5,  4'd9,  1'b0, -1, 1'b0, 1'b0, 9);  // clean run after reset

        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
